// File: rtl/bp_pkg.sv
// Shared types and constants for the fetch-stage branch predictor.
// The counter encoding is chosen so that bit 1 is the predict-taken bit.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_RESET = WNT;
    localparam ctr_t CTR_ALLOC = WT;

    localparam int DEFAULT_IDX_BITS = 6;

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic for a 2-bit saturating branch counter.
module sat_counter2
    import bp_pkg::*;
(
    input  ctr_t ctr,
    input  logic taken,
    output ctr_t ctr_next
);

    always_comb begin
        ctr_next = ctr;
        case (ctr)
            SNT:     ctr_next = taken ? WNT : SNT;
            WNT:     ctr_next = taken ? WT  : SNT;
            WT:      ctr_next = taken ? ST  : WNT;
            ST:      ctr_next = taken ? ST  : WT;
            default: ctr_next = ctr;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT of 2-bit counters plus BTB, looked up combinationally at fetch
// and trained by resolved conditional branches from execute.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int IDX_BITS = DEFAULT_IDX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_f_i,
    output logic        predict_taken_o,
    output logic [31:0] predict_target_o,
    input  logic        execute_is_branch_i,
    input  logic        execute_branch_taken_i,
    input  logic        branch_mispredict_i,
    input  logic [31:0] pc_e_i,
    input  logic [31:0] target_e_i,
    output logic [31:0] branch_count_o,
    output logic [31:0] mispredict_count_o
);

    localparam int TAG_BITS = 30 - IDX_BITS;
    localparam int ENTRIES  = 1 << IDX_BITS;

    logic                valid_mem  [ENTRIES];
    logic [TAG_BITS-1:0] tag_mem    [ENTRIES];
    logic [31:0]         target_mem [ENTRIES];
    ctr_t                ctr_mem    [ENTRIES];

    logic [IDX_BITS-1:0] idx_f, idx_e;
    logic [TAG_BITS-1:0] tag_f, tag_e;
    logic                hit_f, hit_e;
    ctr_t                ctr_next;
    logic                unused_pc_bits;

    assign idx_f = pc_f_i[IDX_BITS+1:2];
    assign tag_f = pc_f_i[31:IDX_BITS+2];
    assign idx_e = pc_e_i[IDX_BITS+1:2];
    assign tag_e = pc_e_i[31:IDX_BITS+2];
    assign unused_pc_bits = ^{pc_f_i[1:0], pc_e_i[1:0]};

    assign hit_f = valid_mem[idx_f] && (tag_mem[idx_f] == tag_f);
    assign hit_e = valid_mem[idx_e] && (tag_mem[idx_e] == tag_e);

    // Lookup reads pre-edge contents, so a same-cycle update is seen only next cycle.
    always_comb begin
        predict_taken_o  = !rst && hit_f && ctr_mem[idx_f][1];
        predict_target_o = predict_taken_o ? target_mem[idx_f] : pc_f_i + 32'd4;
    end

    sat_counter2 u_sat_counter2 (
        .ctr      (ctr_mem[idx_e]),
        .taken    (execute_branch_taken_i),
        .ctr_next (ctr_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_mem[i] <= 1'b0;
                ctr_mem[i]   <= CTR_RESET;
            end
        end else if (execute_is_branch_i) begin
            if (hit_e) begin
                ctr_mem[idx_e] <= ctr_next;
            end else if (execute_branch_taken_i) begin
                valid_mem[idx_e] <= 1'b1;
                ctr_mem[idx_e]   <= CTR_ALLOC;
            end
        end
    end

    // Tag and target need no reset; a taken branch either matches or allocates,
    // so writing both on every taken update is correct in both cases.
    always_ff @(posedge clk) begin
        if (!rst && execute_is_branch_i && execute_branch_taken_i) begin
            tag_mem[idx_e]    <= tag_e;
            target_mem[idx_e] <= target_e_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count_o     <= '0;
            mispredict_count_o <= '0;
        end else if (execute_is_branch_i) begin
            branch_count_o <= branch_count_o + 32'd1;
            if (branch_mispredict_i) begin
                mispredict_count_o <= mispredict_count_o + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: a behavioural model of the tables pushes
// expected predictions and counter values to queues that are drained against the DUT.
module tb_branch_predictor;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } pred_t;

    typedef struct packed {
        logic [31:0] branches;
        logic [31:0] mispredicts;
    } cnt_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_f_i;
    logic        predict_taken_o;
    logic [31:0] predict_target_o;
    logic        execute_is_branch_i;
    logic        execute_branch_taken_i;
    logic        branch_mispredict_i;
    logic [31:0] pc_e_i;
    logic [31:0] target_e_i;
    logic [31:0] branch_count_o;
    logic [31:0] mispredict_count_o;

    int nChecks = 0;
    int nFails  = 0;

    pred_t predQ[$];
    cnt_t  cntQ[$];

    logic        mValid  [64];
    logic [23:0] mTag    [64];
    logic [31:0] mTarget [64];
    int          mCtr    [64];
    logic [31:0] mBranches    = '0;
    logic [31:0] mMispredicts = '0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk                    (clk),
        .rst                    (rst),
        .pc_f_i                 (pc_f_i),
        .predict_taken_o        (predict_taken_o),
        .predict_target_o       (predict_target_o),
        .execute_is_branch_i    (execute_is_branch_i),
        .execute_branch_taken_i (execute_branch_taken_i),
        .branch_mispredict_i    (branch_mispredict_i),
        .pc_e_i                 (pc_e_i),
        .target_e_i             (target_e_i),
        .branch_count_o         (branch_count_o),
        .mispredict_count_o     (mispredict_count_o)
    );

    function automatic int idxOf(input logic [31:0] pc);
        return int'(pc[7:2]);
    endfunction

    function automatic logic [23:0] tagOf(input logic [31:0] pc);
        return pc[31:8];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check the combinational lookup, then the counters after the edge.
    task automatic applyStimulus(input logic [31:0] pcF, input logic isBr, input logic taken,
                                 input logic mispred, input logic [31:0] pcE,
                                 input logic [31:0] tgtE, input logic rstV);
        pred_t p;
        cnt_t  c;
        int    i;
        logic  hitE;
        @(negedge clk);
        rst                    = rstV;
        pc_f_i                 = pcF;
        execute_is_branch_i    = isBr;
        execute_branch_taken_i = taken;
        branch_mispredict_i    = mispred;
        pc_e_i                 = pcE;
        target_e_i             = tgtE;

        i = idxOf(pcF);
        p.taken  = !rstV && mValid[i] && (mTag[i] == tagOf(pcF)) && (mCtr[i] >= 2);
        p.target = p.taken ? mTarget[i] : pcF + 32'd4;
        predQ.push_back(p);

        if (rstV) begin
            for (int k = 0; k < 64; k++) begin
                mValid[k] = 1'b0;
                mCtr[k]   = 1;
            end
            mBranches    = '0;
            mMispredicts = '0;
        end else if (isBr) begin
            mBranches = mBranches + 32'd1;
            if (mispred) mMispredicts = mMispredicts + 32'd1;
            i    = idxOf(pcE);
            hitE = mValid[i] && (mTag[i] == tagOf(pcE));
            if (hitE) begin
                mCtr[i] = taken ? ((mCtr[i] == 3) ? 3 : mCtr[i] + 1)
                                : ((mCtr[i] == 0) ? 0 : mCtr[i] - 1);
                if (taken) mTarget[i] = tgtE;
            end else if (taken) begin
                mValid[i]  = 1'b1;
                mTag[i]    = tagOf(pcE);
                mTarget[i] = tgtE;
                mCtr[i]    = 2;
            end
        end
        c.branches    = mBranches;
        c.mispredicts = mMispredicts;
        cntQ.push_back(c);

        #1;
        p = predQ.pop_front();
        checkOutput("predict_taken", {31'd0, predict_taken_o}, {31'd0, p.taken});
        checkOutput("predict_target", predict_target_o, p.target);

        @(posedge clk);
        #1;
        c = cntQ.pop_front();
        checkOutput("branch_count", branch_count_o, c.branches);
        checkOutput("mispredict_count", mispredict_count_o, c.mispredicts);
    endtask

    task automatic lookup(input logic [31:0] pcF);
        applyStimulus(pcF, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic train(input logic [31:0] pcF, input logic [31:0] pcE, input logic taken,
                         input logic [31:0] tgtE, input logic mispred);
        applyStimulus(pcF, 1'b1, taken, mispred, pcE, tgtE, 1'b0);
    endtask

    initial begin
        logic [31:0] pcs [4];
        pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h104; pcs[3] = 32'h302;
        for (int k = 0; k < 64; k++) begin
            mValid[k] = 1'b0; mTag[k] = '0; mTarget[k] = '0; mCtr[k] = 1;
        end
        rst = 1'b1; pc_f_i = 32'h100; execute_is_branch_i = 1'b0;
        execute_branch_taken_i = 1'b0; branch_mispredict_i = 1'b0;
        pc_e_i = '0; target_e_i = '0;

        // Reset, then an idle lookup
        applyStimulus(32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        lookup(32'h100);

        // First taken update, with fetch on the same index: old contents that cycle
        train(32'h100, 32'h100, 1'b1, 32'h80, 1'b1);
        lookup(32'h100);
        train(32'h100, 32'h100, 1'b0, 32'h80, 1'b1);
        lookup(32'h100);

        // Saturation
        for (int k = 0; k < 4; k++) train(32'h100, 32'h100, 1'b1, 32'h80, 1'b0);
        train(32'h100, 32'h100, 1'b0, 32'h80, 1'b1);
        lookup(32'h100);
        train(32'h100, 32'h100, 1'b0, 32'h80, 1'b1);
        lookup(32'h100);

        // Aliasing between 0x100 and 0x200
        train(32'h100, 32'h100, 1'b1, 32'h80, 1'b1);
        lookup(32'h100);
        lookup(32'h200);
        train(32'h200, 32'h200, 1'b1, 32'h40, 1'b1);
        lookup(32'h200);
        lookup(32'h100);

        // Not-taken miss does not allocate
        train(32'h300, 32'h300, 1'b0, 32'h10, 1'b0);
        lookup(32'h300);

        // Counters: fresh reset, 10 branches with 3 mispredicts, one stray mispredict
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        for (int k = 0; k < 10; k++) train(32'h0, 32'h400, 1'b0, 32'h0, (k % 3) == 0 && k < 9);
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        checkOutput("branch_total", branch_count_o, 32'd10);
        checkOutput("mispredict_total", mispredict_count_o, 32'd3);

        // Random traffic over a few aliasing PCs
        for (int k = 0; k < 60; k++) begin
            applyStimulus(pcs[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          pcs[$urandom_range(0, 3)], {$urandom_range(0, 255), 2'b00}, 1'b0);
        end

        // Reset mid-run with a concurrent update that must be dropped
        applyStimulus(32'h200, 1'b1, 1'b1, 1'b1, 32'h200, 32'h44, 1'b1);
        lookup(32'h200);
        lookup(32'h100);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
